// File: rtl/sram_req_pipe.sv
// sram_req_pipe: CPU-side bridge onto an SRAM-like addr_ok/data_ok bus.
//
// Tracks up to MAX_OUT accepted-but-unanswered requests in an in-order FIFO.
// Each FIFO entry carries only a kill bit, so responses to requests issued
// before a flush are dropped. Two modes:
//   BLOCKING=1: one request at a time. The stall is held until the response
//               is captured in rdata_q and presented in the DONE state.
//   BLOCKING=0: pipelined. The response is passed straight through with
//               cpu_data_ok_o.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush_i         kill all in-flight requests
//   hold_i          pipeline held elsewhere (BLOCKING: stay in DONE)
//   cpu_req_i ..    CPU request: valid, we, addr, wdata, byte select
//   cpu_addr_ok_o   request accepted this cycle
//   cpu_data_ok_o   response for the oldest live request
//   cpu_rdata_o     response data
//   stallreq_o      stall request to ctrl
//   err_o           sticky: data_ok_i seen with nothing in flight
//   req_o .. ben_o  bus request side
//   addr_ok_i       bus request handshake
//   data_ok_i       bus response handshake
//   rdata_i         bus response data
module sram_req_pipe #(
   parameter int unsigned DW       = 32,
   parameter int unsigned AW       = 32,
   parameter int unsigned MAX_OUT  = 4,
   parameter int unsigned BLOCKING = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_i,
   input  logic            hold_i,
   input  logic            cpu_req_i,
   input  logic            cpu_we_i,
   input  logic [AW-1:0]   cpu_addr_i,
   input  logic [DW-1:0]   cpu_wdata_i,
   input  logic [DW/8-1:0] cpu_sel_i,
   output logic            cpu_addr_ok_o,
   output logic            cpu_data_ok_o,
   output logic [DW-1:0]   cpu_rdata_o,
   output logic            stallreq_o,
   output logic            err_o,
   output logic            req_o,
   output logic            wr_o,
   output logic [AW-1:0]   addr_o,
   output logic [DW-1:0]   wdata_o,
   output logic [DW/8-1:0] ben_o,
   input  logic            addr_ok_i,
   input  logic            data_ok_i,
   input  logic [DW-1:0]   rdata_i
);

   localparam int unsigned PtrW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int unsigned CntW = $clog2(MAX_OUT + 1);
   localparam bit IsBlocking = (BLOCKING != 0);

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   state_e            state_q, state_d;
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   out_cnt_q, out_cnt_d;
   logic [MAX_OUT-1:0] kill_q, kill_d;
   logic [DW-1:0]     rdata_q, rdata_d;
   logic              err_q, err_d;

   logic in_flight, accept, pop, head_kill, live_resp, room;

   // Pointers wrap modulo MAX_OUT; MAX_OUT=1 keeps them pinned at 0.
   function automatic logic [PtrW-1:0] inc_ptr(input logic [PtrW-1:0] p);
      if (p == PtrW'(MAX_OUT - 1)) begin
         return '0;
      end
      return p + PtrW'(1);
   endfunction

   assign in_flight = (out_cnt_q != '0);
   assign room      = (out_cnt_q < CntW'(MAX_OUT));
   assign head_kill = kill_q[rd_ptr_q];
   assign pop       = data_ok_i & in_flight;
   // A flush in the same cycle as the response drops it.
   assign live_resp = pop & ~head_kill & ~flush_i;

   assign req_o  = cpu_req_i & ~flush_i & room & (~IsBlocking | (state_q == StIdle));
   assign accept = req_o & addr_ok_i;

   assign wr_o    = cpu_we_i;
   assign addr_o  = cpu_addr_i;
   assign wdata_o = cpu_wdata_i;
   assign ben_o   = cpu_sel_i;

   assign cpu_addr_ok_o = accept;
   assign err_o         = err_q;

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      out_cnt_d = out_cnt_q;
      kill_d    = kill_q;
      rdata_d   = rdata_q;
      err_d     = err_q | (data_ok_i & ~in_flight);
      state_d   = state_q;

      if (accept) begin
         wr_ptr_d         = inc_ptr(wr_ptr_q);
         kill_d[wr_ptr_q] = 1'b0;
      end
      if (pop) begin
         rd_ptr_d = inc_ptr(rd_ptr_q);
      end
      unique case ({accept, pop})
         2'b10:   out_cnt_d = out_cnt_q + CntW'(1);
         2'b01:   out_cnt_d = out_cnt_q - CntW'(1);
         default: out_cnt_d = out_cnt_q;
      endcase
      // req_o is masked by flush_i, so no push can collide with this.
      // Setting kill on free slots is harmless: a push clears it.
      if (flush_i) begin
         kill_d = '1;
      end

      if (IsBlocking) begin
         unique case (state_q)
            StIdle: if (accept) state_d = StWait;
            StWait: begin
               if (flush_i) begin
                  state_d = StIdle;
               end else if (live_resp) begin
                  state_d = StDone;
                  rdata_d = rdata_i;
               end
            end
            StDone: if (!hold_i || flush_i) state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      if (IsBlocking) begin
         cpu_data_ok_o = (state_q == StDone);
         cpu_rdata_o   = rdata_q;
         stallreq_o    = cpu_req_i & (state_q != StDone);
      end else begin
         cpu_data_ok_o = live_resp;
         cpu_rdata_o   = live_resp ? rdata_i : '0;
         stallreq_o    = cpu_req_i & ~accept;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         out_cnt_q <= '0;
         kill_q    <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         out_cnt_q <= out_cnt_d;
         kill_q    <= kill_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_sram_req_pipe.sv
// Bench for sram_req_pipe: one pipelined instance driven from a vector table,
// one blocking instance driven by hand-written step sequences.
module tb_sram_req_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Pipelined instance (BLOCKING=0)
   logic        p_rst, p_flush, p_hold, p_req, p_we, p_aok, p_dok;
   logic [31:0] p_addr, p_wdata, p_rdata_i;
   logic [3:0]  p_sel;
   logic        p_cpu_aok, p_cpu_dok, p_stall, p_err, p_req_o, p_wr_o;
   logic [31:0] p_rdata_o, p_addr_o, p_wdata_o;
   logic [3:0]  p_ben_o;

   sram_req_pipe #(.DW(32), .AW(32), .MAX_OUT(4), .BLOCKING(0)) u_pipe (
      .clk(clk), .rst(p_rst), .flush_i(p_flush), .hold_i(p_hold),
      .cpu_req_i(p_req), .cpu_we_i(p_we), .cpu_addr_i(p_addr), .cpu_wdata_i(p_wdata),
      .cpu_sel_i(p_sel), .cpu_addr_ok_o(p_cpu_aok), .cpu_data_ok_o(p_cpu_dok),
      .cpu_rdata_o(p_rdata_o), .stallreq_o(p_stall), .err_o(p_err), .req_o(p_req_o),
      .wr_o(p_wr_o), .addr_o(p_addr_o), .wdata_o(p_wdata_o), .ben_o(p_ben_o),
      .addr_ok_i(p_aok), .data_ok_i(p_dok), .rdata_i(p_rdata_i)
   );

   // Blocking instance (BLOCKING=1)
   logic        b_rst, b_flush, b_hold, b_req, b_we, b_aok, b_dok;
   logic [31:0] b_addr, b_wdata, b_rdata_i;
   logic [3:0]  b_sel;
   logic        b_cpu_aok, b_cpu_dok, b_stall, b_err, b_req_o, b_wr_o;
   logic [31:0] b_rdata_o, b_addr_o, b_wdata_o;
   logic [3:0]  b_ben_o;

   sram_req_pipe #(.DW(32), .AW(32), .MAX_OUT(4), .BLOCKING(1)) u_blk (
      .clk(clk), .rst(b_rst), .flush_i(b_flush), .hold_i(b_hold),
      .cpu_req_i(b_req), .cpu_we_i(b_we), .cpu_addr_i(b_addr), .cpu_wdata_i(b_wdata),
      .cpu_sel_i(b_sel), .cpu_addr_ok_o(b_cpu_aok), .cpu_data_ok_o(b_cpu_dok),
      .cpu_rdata_o(b_rdata_o), .stallreq_o(b_stall), .err_o(b_err), .req_o(b_req_o),
      .wr_o(b_wr_o), .addr_o(b_addr_o), .wdata_o(b_wdata_o), .ben_o(b_ben_o),
      .addr_ok_i(b_aok), .data_ok_i(b_dok), .rdata_i(b_rdata_i)
   );

   typedef struct {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic        aok;
      logic        dok;
      logic [31:0] rdata;
      logic        flush;
      logic        e_ro;
      logic        e_ao;
      logic        e_do;
      logic [31:0] e_rd;
      logic        e_st;
      logic        e_err;
   } vec_t;

   localparam int NumVec = 26;
   vec_t vecs[NumVec];

   function automatic vec_t mk(input logic req, input logic we, input logic [31:0] addr,
                               input logic [3:0] sel, input logic aok, input logic dok,
                               input logic [31:0] rdata, input logic flush,
                               input logic e_ro, input logic e_ao, input logic e_do,
                               input logic [31:0] e_rd, input logic e_st, input logic e_err);
      vec_t v;
      v.req = req; v.we = we; v.addr = addr; v.sel = sel; v.aok = aok; v.dok = dok;
      v.rdata = rdata; v.flush = flush; v.e_ro = e_ro; v.e_ao = e_ao; v.e_do = e_do;
      v.e_rd = e_rd; v.e_st = e_st; v.e_err = e_err;
      return v;
   endfunction

   task automatic bstep(input string name, input logic req, input logic [31:0] addr,
                        input logic aok, input logic dok, input logic [31:0] rdata,
                        input logic flush, input logic hold,
                        input logic e_ro, input logic e_ao, input logic e_do,
                        input logic [31:0] e_rd, input logic e_st);
      @(negedge clk);
      b_req = req; b_addr = addr; b_wdata = ~addr; b_aok = aok; b_dok = dok;
      b_rdata_i = rdata; b_flush = flush; b_hold = hold;
      #1;
      checks++;
      if ({b_req_o, b_cpu_aok, b_cpu_dok, b_rdata_o, b_stall} !== {e_ro, e_ao, e_do, e_rd, e_st})
      begin
         failures++;
         $display("FAIL blk_%s: got req_o=%0b addr_ok=%0b data_ok=%0b rdata=%08h stall=%0b, want %0b %0b %0b %08h %0b",
                  name, b_req_o, b_cpu_aok, b_cpu_dok, b_rdata_o, b_stall,
                  e_ro, e_ao, e_do, e_rd, e_st);
      end
   endtask

   // Backstop against a stuck simulation.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Pipelined: 6 back-to-back reqs saturate at 4, then pops, flush, stray data_ok.
      vecs[0]  = mk(1,0,32'hA000_0000,4'hF,1,0,32'h0,0,        1,1,0,32'h0,0,0);
      vecs[1]  = mk(1,1,32'hA000_0004,4'h3,1,0,32'h0,0,        1,1,0,32'h0,0,0);
      vecs[2]  = mk(1,0,32'hA000_0008,4'h1,1,0,32'h0,0,        1,1,0,32'h0,0,0);
      vecs[3]  = mk(1,1,32'hA000_000C,4'hC,1,0,32'h0,0,        1,1,0,32'h0,0,0);
      vecs[4]  = mk(1,0,32'hA000_0010,4'hF,1,0,32'h0,0,        0,0,0,32'h0,1,0);
      vecs[5]  = mk(1,0,32'hA000_0010,4'hF,1,0,32'h0,0,        0,0,0,32'h0,1,0);
      vecs[6]  = mk(1,0,32'hA000_0010,4'hF,1,1,32'h1111_1111,0, 0,0,1,32'h1111_1111,1,0);
      vecs[7]  = mk(1,0,32'hA000_0010,4'hF,1,0,32'h0,0,        1,1,0,32'h0,0,0);
      vecs[8]  = mk(1,0,32'hA000_0014,4'hF,0,1,32'h2222_2222,0, 0,0,1,32'h2222_2222,1,0);
      vecs[9]  = mk(1,0,32'hA000_0014,4'hF,1,1,32'h3333_3333,0, 1,1,1,32'h3333_3333,0,0);
      vecs[10] = mk(0,0,32'h0,4'h0,0,1,32'h4444_4444,0,        0,0,1,32'h4444_4444,0,0);
      vecs[11] = mk(1,0,32'hA000_0018,4'hF,1,0,32'h0,0,        1,1,0,32'h0,0,0);
      vecs[12] = mk(1,0,32'hA000_001C,4'hF,1,0,32'h0,1,        0,0,0,32'h0,1,0);
      vecs[13] = mk(1,0,32'hA000_001C,4'hF,1,0,32'h0,0,        1,1,0,32'h0,0,0);
      vecs[14] = mk(0,0,32'h0,4'h0,0,1,32'hAAAA_AAAA,0,        0,0,0,32'h0,0,0);
      vecs[15] = mk(0,0,32'h0,4'h0,0,1,32'hBBBB_BBBB,0,        0,0,0,32'h0,0,0);
      vecs[16] = mk(0,0,32'h0,4'h0,0,1,32'hCCCC_CCCC,0,        0,0,0,32'h0,0,0);
      vecs[17] = mk(0,0,32'h0,4'h0,0,1,32'h1234_5678,0,        0,0,1,32'h1234_5678,0,0);
      vecs[18] = mk(1,0,32'hB000_0000,4'hF,1,0,32'h0,0,        1,1,0,32'h0,0,0);
      vecs[19] = mk(1,1,32'hB000_0004,4'hF,1,0,32'h0,0,        1,1,0,32'h0,0,0);
      vecs[20] = mk(0,0,32'h0,4'h0,0,1,32'h5555_5555,1,        0,0,0,32'h0,0,0);
      vecs[21] = mk(0,0,32'h0,4'h0,0,1,32'h7777_7777,0,        0,0,0,32'h0,0,0);
      vecs[22] = mk(0,0,32'h0,4'h0,0,1,32'h8888_8888,0,        0,0,0,32'h0,0,0);
      vecs[23] = mk(1,0,32'hB000_0008,4'hF,1,0,32'h0,0,        1,1,0,32'h0,0,1);
      vecs[24] = mk(0,0,32'h0,4'h0,0,1,32'h6666_6666,0,        0,0,1,32'h6666_6666,0,1);
      vecs[25] = mk(0,0,32'h0,4'h0,0,0,32'h0,0,                0,0,0,32'h0,0,1);

      {p_flush, p_hold, p_req, p_we, p_aok, p_dok} = '0;
      p_addr = '0; p_wdata = '0; p_rdata_i = '0; p_sel = '0;
      {b_flush, b_hold, b_req, b_we, b_aok, b_dok} = '0;
      b_addr = '0; b_wdata = '0; b_rdata_i = '0; b_sel = '0;
      p_rst = 1'b1; b_rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({p_cpu_aok, p_cpu_dok, p_rdata_o, p_stall, p_err, p_req_o, p_wr_o, p_addr_o,
           p_wdata_o, p_ben_o} !== '0) begin
         failures++;
         $display("FAIL pipe_reset: got outputs not all zero (dok=%0b rdata=%08h err=%0b req_o=%0b), want 0",
                  p_cpu_dok, p_rdata_o, p_err, p_req_o);
      end
      checks++;
      if ({b_cpu_aok, b_cpu_dok, b_rdata_o, b_stall, b_err, b_req_o} !== '0) begin
         failures++;
         $display("FAIL blk_reset: got dok=%0b rdata=%08h stall=%0b err=%0b req_o=%0b, want all 0",
                  b_cpu_dok, b_rdata_o, b_stall, b_err, b_req_o);
      end
      p_rst = 1'b0; b_rst = 1'b0;

      for (int i = 0; i < NumVec; i++) begin
         @(negedge clk);
         p_req = vecs[i].req; p_we = vecs[i].we; p_addr = vecs[i].addr;
         p_wdata = ~vecs[i].addr; p_sel = vecs[i].sel; p_aok = vecs[i].aok;
         p_dok = vecs[i].dok; p_rdata_i = vecs[i].rdata; p_flush = vecs[i].flush;
         #1;
         checks++;
         if ({p_req_o, p_cpu_aok, p_cpu_dok, p_stall, p_err} !==
             {vecs[i].e_ro, vecs[i].e_ao, vecs[i].e_do, vecs[i].e_st, vecs[i].e_err} ||
             (vecs[i].e_do && p_rdata_o !== vecs[i].e_rd)) begin
            failures++;
            $display("FAIL pipe_vec%0d: got req_o=%0b addr_ok=%0b data_ok=%0b rdata=%08h stall=%0b err=%0b, want %0b %0b %0b %08h %0b %0b",
                     i, p_req_o, p_cpu_aok, p_cpu_dok, p_rdata_o, p_stall, p_err,
                     vecs[i].e_ro, vecs[i].e_ao, vecs[i].e_do, vecs[i].e_rd,
                     vecs[i].e_st, vecs[i].e_err);
         end
         checks++;
         if (p_wr_o !== vecs[i].we || p_addr_o !== vecs[i].addr ||
             p_wdata_o !== ~vecs[i].addr || p_ben_o !== vecs[i].sel) begin
            failures++;
            $display("FAIL pipe_bus%0d: got wr=%0b addr=%08h wdata=%08h ben=%h, want %0b %08h %08h %h",
                     i, p_wr_o, p_addr_o, p_wdata_o, p_ben_o, vecs[i].we, vecs[i].addr,
                     ~vecs[i].addr, vecs[i].sel);
         end
      end
      @(negedge clk);
      {p_flush, p_req, p_we, p_aok, p_dok} = '0;

      // Blocking read: accepted cycle 1, response cycle 3, DONE cycle 4.
      bstep("c0",   1, 32'hBFC0_0000, 0, 0, 32'h0,         0, 0, 1, 0, 0, 32'h0,         1);
      bstep("c1",   1, 32'hBFC0_0000, 1, 0, 32'h0,         0, 0, 1, 1, 0, 32'h0,         1);
      bstep("c2",   1, 32'hBFC0_0000, 0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h0,         1);
      bstep("c3",   1, 32'hBFC0_0000, 0, 1, 32'h3C08_BFAF, 0, 0, 0, 0, 0, 32'h0,         1);
      bstep("c4",   1, 32'hBFC0_0000, 0, 0, 32'h0,         0, 0, 0, 0, 1, 32'h3C08_BFAF, 0);
      bstep("c5",   0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 0, 32'h3C08_BFAF, 0);
      // DONE held for 3 cycles by hold_i.
      bstep("h0",   1, 32'hBFC0_0004, 1, 0, 32'h0,         0, 0, 1, 1, 0, 32'h3C08_BFAF, 1);
      bstep("h1",   1, 32'hBFC0_0004, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 32'h3C08_BFAF, 1);
      bstep("h2",   1, 32'hBFC0_0004, 0, 0, 32'h0,         0, 1, 0, 0, 1, 32'hDEAD_BEEF, 0);
      bstep("h3",   1, 32'hBFC0_0004, 0, 0, 32'h0,         0, 1, 0, 0, 1, 32'hDEAD_BEEF, 0);
      bstep("h4",   1, 32'hBFC0_0004, 0, 0, 32'h0,         0, 1, 0, 0, 1, 32'hDEAD_BEEF, 0);
      bstep("h5",   1, 32'hBFC0_0004, 0, 0, 32'h0,         0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
      bstep("h6",   0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0);
      // Flush in WAIT; the killed response arrives after the next request issued.
      bstep("f0",   1, 32'hBFC0_0008, 1, 0, 32'h0,         0, 0, 1, 1, 0, 32'hDEAD_BEEF, 1);
      bstep("f1",   1, 32'hBFC0_0008, 1, 0, 32'h0,         1, 0, 0, 0, 0, 32'hDEAD_BEEF, 1);
      bstep("f2",   1, 32'hBFC0_000C, 1, 0, 32'h0,         0, 0, 1, 1, 0, 32'hDEAD_BEEF, 1);
      bstep("f3",   1, 32'hBFC0_000C, 0, 1, 32'hBAD0_0BAD, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 1);
      bstep("f4",   1, 32'hBFC0_000C, 0, 1, 32'h0000_CAFE, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 1);
      bstep("f5",   1, 32'hBFC0_000C, 0, 0, 32'h0,         0, 0, 0, 0, 1, 32'h0000_CAFE, 0);
      // Reset while in WAIT.
      bstep("r0",   1, 32'hBFC0_0010, 1, 0, 32'h0,         0, 0, 1, 1, 0, 32'h0000_CAFE, 1);
      @(negedge clk);
      {b_flush, b_hold, b_req, b_we, b_aok, b_dok} = '0;
      b_addr = '0; b_wdata = '0; b_rdata_i = '0; b_sel = '0;
      b_rst = 1'b1;
      @(negedge clk);
      b_rst = 1'b0;
      #1;
      checks++;
      if ({b_cpu_aok, b_cpu_dok, b_rdata_o, b_stall, b_err, b_req_o, b_wr_o, b_addr_o,
           b_wdata_o, b_ben_o} !== '0) begin
         failures++;
         $display("FAIL blk_rst_wait: got dok=%0b rdata=%08h stall=%0b err=%0b req_o=%0b, want all 0",
                  b_cpu_dok, b_rdata_o, b_stall, b_err, b_req_o);
      end
      bstep("r1",   1, 32'hBFC0_0014, 0, 0, 32'h0,         0, 0, 1, 0, 0, 32'h0,         1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
